pwf_arb: RTL
============

Name: pwf_arb

Overview:
- Multi-channel pulse-width filter with an event scheduler. Each raw switch input is filtered into a stable level with a minimum high time and a minimum low time.
- Every filtered edge becomes a press or release event.
- A round-robin arbiter serialises pending events from all channels onto one valid/ready event port.
- Sits between raw board switches (sampled on clk4m) and the control logic that consumes key events.

Parameters:
- N_CH, 4, number of switch channels (2..16).
- HI_CYC, 12, consecutive high samples required to set filtered level c (1..2^CNT_W-1).
- LO_CYC, 12, consecutive low samples required to clear filtered level c (1..2^CNT_W-1).
- CNT_W, 4, width of each per-channel filter counter.

Ports:
- clk4m  in  1  system clock, 4 MHz; all state on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- a  in  N_CH  raw switch inputs; already synchronised upstream.
- c  out  N_CH  filtered switch levels.
- evt_valid  out  1  event output holds a valid event.
- evt_ready  in  1  consumer accepts the event.
- evt_ch  out  CH_W  channel index of the event; CH_W = max(1, clog2(N_CH)).
- evt_press  out  1  1 = press (c rose), 0 = release (c fell).
- ovf  out  N_CH  sticky per channel: an event was overwritten before it was served.
- ovf_clr  in  1  single-cycle pulse; clears all ovf bits.

Behaviour:
- Reset: c = 0, all counters = 0, pending = 0, ovf = 0, evt_valid = 0, evt_ch = 0, evt_press = 0, round-robin pointer = 0. Reset is asynchronous and may assert mid-operation; any queued event is discarded.

Per-channel filter:
- Counter clears on any cycle where a[i] == c[i].
- While a[i] != c[i], the counter increments by 1 per cycle and saturates at 2^CNT_W-1.
- c[i] toggles on the edge where the HI_CYC-th consecutive high sample (rising) or the LO_CYC-th consecutive low sample (falling) is taken. The counter clears on that same edge.
- A glitch shorter than the threshold leaves c unchanged.

Pending event:
- When c[i] toggles, pending[i] is set to 1 and pend_pol[i] is set to the new c[i], on the same edge.
- If pending[i] is already 1 and is not being loaded into the output that cycle: ovf[i] is set and pend_pol[i] is overwritten with the newest polarity.
- If the toggle coincides with pending[i] being loaded into the output: pending[i] stays set with the new polarity and ovf is not set.
- ovf set and ovf_clr in the same cycle: set wins.

Output register and handshake:
- The register loads when evt_valid == 0, or when evt_valid && evt_ready.
- On load, the arbiter picks the first pending channel at or after the pointer (wrapping at N_CH-1 to 0). It drives evt_ch and evt_press, sets evt_valid, clears that pending bit, and moves the pointer to winner+1 mod N_CH.
- If a load is allowed but nothing is pending, evt_valid goes to 0.
- evt_valid, evt_ch and evt_press stay stable while evt_valid && !evt_ready.
- Latency: c toggles at edge k, and evt_valid can be 1 after edge k+1 at the earliest.
- Throughput: 1 event per cycle when evt_ready is held high.

State machine:
- The output side is a 2-state FSM: IDLE (evt_valid = 0) and HOLD (evt_valid = 1).
- IDLE -> HOLD when any channel is pending.
- HOLD -> IDLE on accept when nothing is pending.
- HOLD -> HOLD on accept when something is pending; the next event is loaded back-to-back.

Optional Feature:
- Macro: PWF_ARB_REL_EVT_EN.
- Defined: both press and release events are queued, as described above.
- Undefined: only rising edges of c set pending, and evt_press is tied to 1. Falling edges still update c but produce no event, and a release never sets ovf.

Decomposition:
- Package pwf_pkg holds:
  - the CH_W derivation function;
  - the typedef pwf_evt_t, a packed struct of ch and press;
  - the typedef out_state_t enum {IDLE, HOLD};
  - default threshold constants PWF_HI_CYC_DEF = 12 and PWF_LO_CYC_DEF = 12.
- Sub-module pwf_chan: one channel's counter and c register, with a one-cycle toggle strobe output. It is instantiated N_CH times via generate.
- The arbiter, pending/ovf bookkeeping and output FSM stay in pwf_arb.

Test Plan:
- Glitch rejection: a[0] high for 11 cycles, then low -> c[0] stays 0, no event, ovf = 0.
- Press/release: a[1] high for 20 cycles, then low for 20, with evt_ready = 1.
  - c[1] rises on the 12th high sample, then evt_valid with ch = 1, press = 1 the cycle after.
  - c[1] falls on the 12th low sample, then an event with press = 0.
- Round-robin: raise a[0], a[2] and a[3] simultaneously with evt_ready = 0 for 30 cycles, then evt_ready = 1.
  - Events are ch 0, 2, 3 on consecutive cycles.
  - Repeating the same raise/release pattern with pointer = 1 gives release events in order 2, 3, 0.
- Backpressure/overflow: hold evt_ready = 0, toggle a[2] to press then release, both filtered.
  - ovf[2] = 1, and the single pending event for ch 2 shows press = 0.
  - ovf_clr pulse -> ovf[2] = 0.
- Coincident load and toggle: c[1] toggles on the same edge its pending event is loaded -> no ovf, and a second event for ch 1 follows.
- Reset mid-operation: assert rst_n = 0 while evt_valid = 1 and two channels are pending -> all outputs 0 asynchronously, and after release no stale events appear.
- Macro undefined: the press/release scenario yields exactly one event with press = 1.

Source files
------------

// File: rtl/pwf_pkg.sv
// Shared types and constants for the pwf_arb switch filter / event scheduler.
package pwf_pkg;

  localparam int PWF_HI_CYC_DEF = 12;
  localparam int PWF_LO_CYC_DEF = 12;
  // Widest channel index the event struct can carry (N_CH up to 16).
  localparam int PWF_CH_W_MAX   = 4;

  function automatic int pwf_ch_w(input int n_ch);
    return (n_ch <= 2) ? 1 : $clog2(n_ch);
  endfunction

  typedef struct packed {
    logic [PWF_CH_W_MAX-1:0] ch;
    logic                    press;
  } pwf_evt_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } out_state_t;

endpackage

// File: rtl/pwf_chan.sv
// One switch channel: run-length filter with separate high/low thresholds and a
// combinational toggle strobe that is high in the cycle whose edge flips c_o.
module pwf_chan
  import pwf_pkg::*;
#(
  parameter int HI_CYC = PWF_HI_CYC_DEF,
  parameter int LO_CYC = PWF_LO_CYC_DEF,
  parameter int CNT_W  = 4
) (
  input  logic clk4m,
  input  logic rst_n,
  input  logic a_i,
  output logic c_o,
  output logic tgl_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] thr_m1;
  logic             c_q, c_d;

  // cnt_q holds the number of differing samples already taken, so the edge
  // that takes the threshold-th sample is the one where cnt_q == threshold-1.
  always_comb begin
    thr_m1 = c_q ? CNT_W'(LO_CYC - 1) : CNT_W'(HI_CYC - 1);
    tgl_o  = (a_i != c_q) && (cnt_q == thr_m1);
    c_d    = c_q ^ tgl_o;
    cnt_d  = cnt_q;
    if ((a_i == c_q) || tgl_o) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk4m or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      c_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      c_q   <= c_d;
    end
  end

  assign c_o = c_q;

endmodule

// File: rtl/pwf_arb.sv
// Multi-channel pulse-width filter with round-robin event scheduler.
// Build with PWF_ARB_REL_EVT_EN defined to also queue release events.
module pwf_arb
  import pwf_pkg::*;
#(
  parameter  int N_CH   = 4,
  parameter  int HI_CYC = PWF_HI_CYC_DEF,
  parameter  int LO_CYC = PWF_LO_CYC_DEF,
  parameter  int CNT_W  = 4,
  localparam int CH_W   = pwf_ch_w(N_CH)
) (
  input  logic            clk4m,
  input  logic            rst_n,
  input  logic [N_CH-1:0] a,
  output logic [N_CH-1:0] c,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [CH_W-1:0] evt_ch,
  output logic            evt_press,
  output logic [N_CH-1:0] ovf,
  input  logic            ovf_clr,
  output out_state_t      dbg_state
);

  logic [N_CH-1:0] tgl, set, win_oh;
  logic [N_CH-1:0] pend_q, pend_d;
  logic [N_CH-1:0] ovf_q, ovf_d;
  logic [CH_W-1:0] ptr_q, ptr_d, win, arb_idx;
  logic            any_pend, load, load_win;
  pwf_evt_t        evt_q, evt_d;
  out_state_t      state_q, state_d;

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    pwf_chan #(
      .HI_CYC(HI_CYC),
      .LO_CYC(LO_CYC),
      .CNT_W (CNT_W)
    ) u_chan (
      .clk4m(clk4m),
      .rst_n(rst_n),
      .a_i  (a[i]),
      .c_o  (c[i]),
      .tgl_o(tgl[i])
    );
  end

  // First pending channel at or after the pointer, wrapping past N_CH-1.
  always_comb begin
    any_pend = 1'b0;
    win      = '0;
    arb_idx  = '0;
    for (int k = 0; k < N_CH; k++) begin
      arb_idx = CH_W'((int'(ptr_q) + k) % N_CH);
      if (!any_pend && pend_q[arb_idx]) begin
        any_pend = 1'b1;
        win      = arb_idx;
      end
    end
  end

  // Handshake: an event transfers on an edge where evt_valid && evt_ready;
  // while evt_valid && !evt_ready, evt_valid/evt_ch/evt_press hold steady.
  assign load     = !evt_valid || evt_ready;
  assign load_win = load && any_pend;
  assign win_oh   = load_win ? (N_CH'(1) << win) : '0;

`ifdef PWF_ARB_REL_EVT_EN
  logic [N_CH-1:0] pol_q, pol_d;
  assign set   = tgl;
  assign pol_d = (pol_q & ~tgl) | (~c & tgl);
`else
  assign set   = tgl & ~c;
`endif

  // A toggle on the channel being loaded re-arms pending without overflow.
  assign pend_d = (pend_q & ~win_oh) | set;
  assign ovf_d  = (ovf_clr ? '0 : ovf_q) | (set & pend_q & ~win_oh);

  always_comb begin
    state_d = state_q;
    evt_d   = evt_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE:    if (any_pend) state_d = HOLD;
      HOLD:    if (evt_ready) state_d = any_pend ? HOLD : IDLE;
      default: state_d = IDLE;
    endcase
    if (load_win) begin
      evt_d.ch = PWF_CH_W_MAX'(win);
`ifdef PWF_ARB_REL_EVT_EN
      evt_d.press = pol_q[win];
`else
      evt_d.press = 1'b1;
`endif
      ptr_d = (win == CH_W'(N_CH - 1)) ? '0 : win + CH_W'(1);
    end
  end

  always_ff @(posedge clk4m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      evt_q   <= '0;
      ptr_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= '0;
`ifdef PWF_ARB_REL_EVT_EN
      pol_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      evt_q   <= evt_d;
      ptr_q   <= ptr_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
`ifdef PWF_ARB_REL_EVT_EN
      pol_q   <= pol_d;
`endif
    end
  end

  assign evt_valid = (state_q == HOLD);
  assign evt_ch    = CH_W'(evt_q.ch);
  assign evt_press = evt_q.press;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule
